// File: rtl/ysyx_lsu_axi_bridge.sv
// ----------------------------------------------------------------------------
// ysyx_lsu_axi_bridge
//
// Purpose:
//   Turns the LSU's level-held load/store requests into single-beat AXI4-Lite
//   read/write transactions and returns a one-cycle completion pulse to the
//   LSU. One transaction is outstanding at a time and there is no buffering.
//   Every output is driven straight from a flop.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   lsu_ar* / lsu_rstrb      load request (address, size mask, valid)
//   lsu_rdata, lsu_rvalid    raw read word and load-done pulse
//   lsu_aw* / lsu_w*         store request (address, data, size mask, valids)
//   lsu_wready               store-done pulse
//   lsu_err_o                error flag, pulses with the done pulse
//   ar*, r*, aw*, w*, b*     AXI4-Lite master channels
// ----------------------------------------------------------------------------
module ysyx_lsu_axi_bridge #(
    parameter int BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    // LSU load side
    input  logic [BIT_W-1:0] lsu_araddr,
    input  logic             lsu_arvalid,
    input  logic [7:0]       lsu_rstrb,
    output logic [BIT_W-1:0] lsu_rdata,
    output logic             lsu_rvalid,
    // LSU store side
    input  logic [BIT_W-1:0] lsu_awaddr,
    input  logic             lsu_awvalid,
    input  logic [BIT_W-1:0] lsu_wdata,
    input  logic [7:0]       lsu_wstrb,
    input  logic             lsu_wvalid,
    output logic             lsu_wready,
    output logic             lsu_err_o,
    // AXI read address
    output logic [BIT_W-1:0] araddr,
    output logic [2:0]       arsize,
    output logic             arvalid,
    input  logic             arready,
    // AXI read data
    input  logic [BIT_W-1:0] rdata,
    input  logic [1:0]       rresp,
    input  logic             rvalid,
    output logic             rready,
    // AXI write address
    output logic [BIT_W-1:0] awaddr,
    output logic [2:0]       awsize,
    output logic             awvalid,
    input  logic             awready,
    // AXI write data
    output logic [BIT_W-1:0] wdata,
    output logic [3:0]       wstrb,
    output logic             wvalid,
    input  logic             wready,
    // AXI write response
    input  logic [1:0]       bresp,
    input  logic             bvalid,
    output logic             bready
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP, S_DONE, S_REARM
    } state_t;

    state_t state_q, state_d;

    logic [BIT_W-1:0] addr_q, addr_d;
    logic [2:0]       size_q, size_d;
    logic [BIT_W-1:0] wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [BIT_W-1:0] lsu_rdata_q, lsu_rdata_d;
    logic             lsu_rvalid_q, lsu_rvalid_d;
    logic             lsu_wready_q, lsu_wready_d;
    logic             lsu_err_q, lsu_err_d;
    logic             arvalid_q, arvalid_d;
    logic             rready_q, rready_d;
    logic             awvalid_q, awvalid_d;
    logic             wvalid_q, wvalid_d;
    logic             bready_q, bready_d;

    logic store_req;
    logic any_req;
    logic aw_done;
    logic w_done;

    // Size mask to AXI size; unknown masks fall back to a full word.
    function automatic logic [2:0] mask_to_size(input logic [7:0] mask);
        case (mask)
            8'h01:   mask_to_size = 3'd0;
            8'h03:   mask_to_size = 3'd1;
            default: mask_to_size = 3'd2;
        endcase
    endfunction

    // Move the right-aligned byte mask to its lane; bits shifted past lane 3
    // are dropped (misaligned accesses are not split).
    function automatic logic [3:0] align_strb(input logic [3:0] mask,
                                              input logic [1:0] off);
        case (off)
            2'd0:    align_strb = mask;
            2'd1:    align_strb = {mask[2:0], 1'b0};
            2'd2:    align_strb = {mask[1:0], 2'b00};
            default: align_strb = {mask[0], 3'b000};
        endcase
    endfunction

    assign store_req = lsu_awvalid & lsu_wvalid;
    assign any_req   = lsu_arvalid | lsu_awvalid | lsu_wvalid;
    // A write channel is finished once its valid has dropped or it handshakes now.
    assign aw_done   = ~awvalid_q | awready;
    assign w_done    = ~wvalid_q | wready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (store_req) begin
                    state_d = S_WR_REQ;
                end else if (lsu_arvalid) begin
                    state_d = S_RD_ADDR;
                end
            end
            S_RD_ADDR: if (arready)           state_d = S_RD_DATA;
            S_RD_DATA: if (rvalid)            state_d = S_DONE;
            S_WR_REQ:  if (aw_done && w_done) state_d = S_WR_RESP;
            S_WR_RESP: if (bvalid)            state_d = S_DONE;
            S_DONE:                           state_d = S_REARM;
            // Hold here until the LSU releases its request so it is not reissued.
            S_REARM:   if (!any_req)          state_d = S_IDLE;
            default:                          state_d = S_IDLE;
        endcase
    end

    // Output and datapath logic; outputs are computed one cycle early so
    // that every port comes straight from a flop.
    always_comb begin
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        lsu_rdata_d = lsu_rdata_q;

        if (state_q == S_IDLE) begin
            if (store_req) begin
                addr_d  = lsu_awaddr;
                size_d  = mask_to_size(lsu_wstrb);
                wstrb_d = align_strb(lsu_wstrb[3:0], lsu_awaddr[1:0]);
                wdata_d = lsu_wdata << {lsu_awaddr[1:0], 3'b000};
            end else if (lsu_arvalid) begin
                addr_d  = lsu_araddr;
                size_d  = mask_to_size(lsu_rstrb);
            end
        end

        if (state_q == S_RD_DATA && rvalid) begin
            lsu_rdata_d = rdata;
        end

        arvalid_d = (state_d == S_RD_ADDR);
        rready_d  = (state_d == S_RD_DATA);
        bready_d  = (state_d == S_WR_RESP);

        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        if (state_q == S_IDLE && state_d == S_WR_REQ) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
        end else if (state_q == S_WR_REQ) begin
            awvalid_d = awvalid_q & ~awready;
            wvalid_d  = wvalid_q & ~wready;
        end

        // The done pulse and error flag are registered on the response
        // handshake, so they are visible during the DONE cycle.
        lsu_rvalid_d = (state_q == S_RD_DATA) & rvalid;
        lsu_wready_d = (state_q == S_WR_RESP) & bvalid;
        lsu_err_d    = ((state_q == S_RD_DATA) & rvalid & (|rresp))
                     | ((state_q == S_WR_RESP) & bvalid & (|bresp));
    end

    // Output and latched-request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            lsu_rdata_q  <= '0;
            lsu_rvalid_q <= 1'b0;
            lsu_wready_q <= 1'b0;
            lsu_err_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            lsu_rdata_q  <= lsu_rdata_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            lsu_wready_q <= lsu_wready_d;
            lsu_err_q    <= lsu_err_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
        end
    end

    assign lsu_rdata  = lsu_rdata_q;
    assign lsu_rvalid = lsu_rvalid_q;
    assign lsu_wready = lsu_wready_q;
    assign lsu_err_o  = lsu_err_q;
    assign araddr     = addr_q;
    assign arsize     = size_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign awaddr     = addr_q;
    assign awsize     = size_q;
    assign awvalid    = awvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign wvalid     = wvalid_q;
    assign bready     = bready_q;

endmodule

// File: tb/tb_ysyx_lsu_axi_bridge.sv
// ----------------------------------------------------------------------------
// Testbench for ysyx_lsu_axi_bridge: LSU-side driver, AXI4-Lite slave model
// with programmable wait states, and a scoreboard that checks AXI request
// fields and LSU completions against expectations queued at issue time.
// ----------------------------------------------------------------------------
module tb_ysyx_lsu_axi_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] lsu_araddr;
    logic        lsu_arvalid;
    logic [7:0]  lsu_rstrb;
    logic [31:0] lsu_rdata;
    logic        lsu_rvalid;
    logic [31:0] lsu_awaddr;
    logic        lsu_awvalid;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wstrb;
    logic        lsu_wvalid;
    logic        lsu_wready;
    logic        lsu_err_o;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    ysyx_lsu_axi_bridge #(.BIT_W(32)) dut (
        .clk(clk), .rst(rst),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_err_o(lsu_err_o),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_wr;
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } lsu_exp_t;

    lsu_exp_t    exp_lsu[$];
    logic [34:0] exp_ar[$];     // {size, addr}
    logic [34:0] exp_aw[$];     // {size, addr}
    logic [35:0] exp_w[$];      // {strb, data}
    logic [33:0] rd_resp_q[$];  // {resp, data} the slave returns
    logic [1:0]  b_resp_q[$];

    int checks = 0;
    int errors = 0;

    // Slave wait states for the next transaction
    int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;

    int          t_issue = 0;
    int          arv_cyc = 0, awv_cyc = 0, wv_cyc = 0;
    logic [31:0] model_rdata = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_size(input logic [7:0] m);
        if (m == 8'h01) return 3'd0;
        if (m == 8'h03) return 3'd1;
        return 3'd2;
    endfunction

    // ---------------- AXI slave model + AXI-side monitor ----------------
    initial begin : slave
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
        logic [34:0] s_ar, s_aw;
        logic [35:0] s_w;
        logic [33:0] rr;
        bit rd_pend, aw_got, w_got, b_pend;
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        forever begin
            @(posedge clk);
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            s_ar  = {arsize, araddr};
            s_aw  = {awsize, awaddr};
            s_w   = {wstrb, wdata};
            if (ar_hs) begin
                check("ar_expected", exp_ar.size() != 0, 1);
                if (exp_ar.size() != 0) check("ar_size_addr", s_ar, exp_ar.pop_front());
            end
            if (aw_hs) begin
                check("aw_expected", exp_aw.size() != 0, 1);
                if (exp_aw.size() != 0) check("aw_size_addr", s_aw, exp_aw.pop_front());
            end
            if (w_hs) begin
                check("w_expected", exp_w.size() != 0, 1);
                if (exp_w.size() != 0) check("w_strb_data", s_w, exp_w.pop_front());
            end
            @(negedge clk);
            if (rst) begin
                rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                arready = 0; rvalid = 0; rdata = 0; rresp = 0;
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                continue;
            end
            // read address
            if (ar_hs) begin
                arready = 0; ar_cnt = 0; rd_pend = 1; r_cnt = 0;
            end else if (arvalid) begin
                arready = (ar_cnt >= ar_wait); ar_cnt++;
            end
            // read data
            if (r_hs) begin
                rvalid = 0; rdata = 0; rresp = 0;
            end else if (rd_pend) begin
                if (r_cnt >= r_wait) begin
                    rr = (rd_resp_q.size() != 0) ? rd_resp_q.pop_front() : 34'h0;
                    rvalid = 1; rdata = rr[31:0]; rresp = rr[33:32]; rd_pend = 0;
                end else r_cnt++;
            end
            // write address / data, independent
            if (aw_hs) begin
                awready = 0; aw_got = 1;
            end else if (awvalid && !aw_got) begin
                awready = (aw_cnt >= aw_wait); aw_cnt++;
            end
            if (w_hs) begin
                wready = 0; w_got = 1;
            end else if (wvalid && !w_got) begin
                wready = (w_cnt >= w_wait); w_cnt++;
            end
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_pend = 1; b_cnt = 0;
            end
            // write response
            if (b_hs) begin
                bvalid = 0; bresp = 0;
            end else if (b_pend) begin
                if (b_cnt >= b_wait) begin
                    bvalid = 1;
                    bresp = (b_resp_q.size() != 0) ? b_resp_q.pop_front() : 2'd0;
                    b_pend = 0;
                end else b_cnt++;
            end
        end
    end

    // ---------------- LSU-side monitor / scoreboard ----------------
    initial begin : monitor
        bit prev_pulse;
        lsu_exp_t e;
        prev_pulse = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pulse = 0;
                continue;
            end
            if (arvalid) arv_cyc++;
            if (awvalid) awv_cyc++;
            if (wvalid)  wv_cyc++;
            if (lsu_rvalid || lsu_wready) begin
                check("pulse_single_cycle", prev_pulse, 0);
                check("lsu_expected", exp_lsu.size() != 0, 1);
                if (exp_lsu.size() != 0) begin
                    e = exp_lsu.pop_front();
                    check("done_kind", {lsu_wready, lsu_rvalid}, e.is_wr ? 2'b10 : 2'b01);
                    check("lsu_rdata", lsu_rdata, e.rdata);
                    check("lsu_err_o", lsu_err_o, e.err);
                    if (e.lat >= 0) check("latency", cyc - t_issue, e.lat);
                end
            end else if (lsu_err_o) begin
                check("err_without_done", lsu_err_o, 0);
            end
            prev_pulse = lsu_rvalid || lsu_wready;
        end
    end

    // ---------------- LSU driver ----------------
    task automatic drop_inputs();
        lsu_arvalid = 0; lsu_awvalid = 0; lsu_wvalid = 0;
    endtask

    // Issue one request, wait for its completion pulse, optionally keep the
    // request held for extra cycles, then release it for one cycle.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [7:0] mask,
                           input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] resp,
                           input int lat, input int hold, input bit noise);
        lsu_exp_t e;
        logic [7:0] s8;
        int off;
        bit done;
        off = int'(addr[1:0]);
        e.is_wr = wr;
        e.err   = (resp != 2'd0);
        e.lat   = lat;
        if (wr) begin
            e.rdata = model_rdata;
            s8 = (mask & 8'h0f) << off;
            exp_aw.push_back({ref_size(mask), addr});
            exp_w.push_back({s8[3:0], wd << (8 * off)});
            b_resp_q.push_back(resp);
        end else begin
            e.rdata = rd;
            model_rdata = rd;
            exp_ar.push_back({ref_size(mask), addr});
            rd_resp_q.push_back({resp, rd});
        end
        exp_lsu.push_back(e);
        @(negedge clk);
        t_issue = cyc; arv_cyc = 0; awv_cyc = 0; wv_cyc = 0;
        if (wr) begin
            lsu_awaddr = addr; lsu_wdata = wd; lsu_wstrb = mask;
            lsu_awvalid = 1; lsu_wvalid = 1;
            if (noise) begin lsu_araddr = $urandom; lsu_rstrb = 8'h01; lsu_arvalid = 1; end
        end else begin
            lsu_araddr = addr; lsu_rstrb = mask; lsu_arvalid = 1;
            if (noise) begin lsu_awaddr = $urandom; lsu_awvalid = 1; end
        end
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (noise) begin
                lsu_araddr = $urandom; lsu_awaddr = $urandom; lsu_wdata = $urandom;
                lsu_wstrb = 8'($urandom); lsu_rstrb = 8'($urandom);
            end
            if (lsu_rvalid || lsu_wready) done = 1;
        end
        if (!done) check("done_timeout", 0, 1);
        repeat (hold) @(negedge clk);
        drop_inputs();
        @(negedge clk);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0]  masks [4];
        logic [1:0]  resps [5];
        bit wr, nz;
        logic [7:0] m;
        logic [1:0] rs;
        int h;
        bit got;
        masks = '{8'h01, 8'h03, 8'h0f, 8'h07};
        resps = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd3};

        rst = 1;
        lsu_araddr = 0; lsu_arvalid = 0; lsu_rstrb = 0;
        lsu_awaddr = 0; lsu_awvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wvalid = 0;
        repeat (3) @(negedge clk);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_aw_w_valid", {awvalid, wvalid}, 2'b00);
        check("rst_bready", bready, 0);
        check("rst_lsu_pulses", {lsu_rvalid, lsu_wready, lsu_err_o}, 3'b000);
        check("rst_lsu_rdata", lsu_rdata, 32'h0);
        check("rst_addr", {araddr, awaddr}, 64'h0);
        check("rst_wdata_wstrb", {wstrb, wdata}, 36'h0);
        rst = 0;
        @(negedge clk);

        // Word load, zero-wait slave
        run_txn(0, 32'h8000_0004, 8'h0f, 0, 32'hDEAD_BEEF, 2'd0, 3, 0, 0);
        // Byte store to the top lane
        run_txn(1, 32'h8000_0003, 8'h01, 32'h0000_00AB, 0, 2'd0, 3, 0, 0);
        // awready late by 3 cycles, wready immediate
        aw_wait = 3;
        run_txn(1, 32'h8000_0010, 8'h0f, 32'h1234_5678, 0, 2'd0, 6, 0, 0);
        check("wvalid_cycles", wv_cyc, 1);
        check("awvalid_cycles", awv_cyc, 4);
        aw_wait = 0;
        // SLVERR on a load
        run_txn(0, 32'h8000_0020, 8'h03, 0, 32'hCAFE_F00D, 2'd2, 3, 0, 0);
        // Load request held two cycles past completion: must not reissue
        run_txn(0, 32'h8000_0030, 8'h0f, 0, 32'h0BAD_F00D, 2'd0, 3, 2, 0);
        check("held_arvalid_cycles", arv_cyc, 1);
        run_txn(0, 32'h8000_0034, 8'h0f, 0, 32'h1111_2222, 2'd0, 3, 0, 0);

        // Reset while waiting in the read-data phase
        r_wait = 10;
        exp_ar.push_back({3'd2, 32'h8000_0040});
        rd_resp_q.push_back({2'd0, 32'h5555_AAAA});
        @(negedge clk);
        lsu_araddr = 32'h8000_0040; lsu_rstrb = 8'h0f; lsu_arvalid = 1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rready) got = 1;
        end
        check("rready_before_rst", rready, 1);
        #1 rst = 1;
        #1 check("rst_drops_rready_arvalid", {rready, arvalid}, 2'b00);
        check("rst_drops_lsu_rdata", lsu_rdata, 32'h0);
        drop_inputs();
        rd_resp_q.delete(); exp_ar.delete();
        model_rdata = 0;
        r_wait = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        run_txn(0, 32'h8000_0044, 8'h0f, 0, 32'h7777_8888, 2'd0, 3, 0, 0);

        // Randomized traffic with wait states, error responses and input noise
        for (int n = 0; n < 150; n++) begin
            ar_wait = $urandom_range(0, 3); r_wait = $urandom_range(0, 3);
            aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3);
            b_wait  = $urandom_range(0, 3);
            wr = $urandom_range(0, 1);
            nz = ($urandom_range(0, 3) == 0);
            m  = masks[$urandom_range(0, 3)];
            rs = resps[$urandom_range(0, 4)];
            h  = $urandom_range(0, 2);
            run_txn(wr, $urandom, m, $urandom, $urandom, rs,
                    wr ? 3 + ((aw_wait > w_wait) ? aw_wait : w_wait) + b_wait
                       : 3 + ar_wait + r_wait,
                    h, nz);
        end

        repeat (5) @(negedge clk);
        check("lsu_queue_drained", exp_lsu.size(), 0);
        check("ar_queue_drained", exp_ar.size(), 0);
        check("aw_w_queues_drained", exp_aw.size() + exp_w.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
